vmem1_arb: RTL and testbench

- Access controller for the stage-1 virtual memory map RAM: 1024 x 24, synchronous read with read enable, synchronous write, read suppressed when write is active.
- Arbitrates the single RAM address port between two requesters:
  - the CPU map-lookup path (latency-critical);
  - the map-write path (loads entries from the VMA).
- Bounds write starvation with a defer counter.
- Optionally sweeps the whole map to a clear value after reset.
- Sits between the map-address/VMA datapath and the VMEM1 RAM instance.

---
 rtl/vmem1_arb_if.sv | 50 +++++
 rtl/vmem1_arb.sv | 143 ++++++++++++++
 tb/tb_vmem1_arb.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmem1_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : vmem1_arb_if
// Description : Signal bundle for the stage-1 map RAM arbiter: lookup port,
//               map-write port, RAM-side port and sweep status.
// Revision    : 1.0  initial release
// ============================================================================
interface vmem1_arb_if #(
    parameter int ADR_W  = 10,
    parameter int DATA_W = 24
);
    // lookup requester
    logic              lk_req;
    logic [ADR_W-1:0]  lk_adr;
    logic              lk_gnt;
    logic              lk_valid;
    logic [DATA_W-1:0] lk_data;

    // map-write requester
    logic              wr_req;
    logic [ADR_W-1:0]  wr_adr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    // RAM side
    logic [ADR_W-1:0]  ram_adr;
    logic              ram_rp;
    logic              ram_wp;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    // status
    logic              busy;

    // Environment side: requesters plus the RAM read data
    modport master (
        output lk_req, lk_adr, wr_req, wr_adr, wr_data, ram_q,
        input  lk_gnt, lk_valid, lk_data, wr_gnt,
        input  ram_adr, ram_rp, ram_wp, ram_wdata, busy
    );

    // Arbiter side
    modport slave (
        input  lk_req, lk_adr, wr_req, wr_adr, wr_data, ram_q,
        output lk_gnt, lk_valid, lk_data, wr_gnt,
        output ram_adr, ram_rp, ram_wp, ram_wdata, busy
    );
endinterface

`default_nettype wire

// File: rtl/vmem1_arb.sv
`default_nettype none
// ============================================================================
// Module      : vmem1_arb
// Description : Access controller for the stage-1 virtual memory map RAM.
//               Arbitrates the single RAM port between CPU map lookups
//               (priority) and map writes (starvation bounded by MAX_DEFER).
//               Define VMEM1_CLEAR_EN to sweep the map to CLEAR_VALUE after
//               every reset; busy is high while the sweep runs.
// Revision    : 1.0  initial release
// ============================================================================
module vmem1_arb #(
    parameter int                ADR_W       = 10,
    parameter int                DATA_W      = 24,
    parameter int                MAX_DEFER   = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = 24'h000000
) (
    input  wire logic  clk,
    input  wire logic  reset,
    vmem1_arb_if.slave bus
);

    localparam logic [3:0] c_MAX_DEFER = 4'(MAX_DEFER);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

`ifdef VMEM1_CLEAR_EN
    localparam state_t c_ST_RESET = ST_CLEAR;
`else
    localparam state_t c_ST_RESET = ST_RUN;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ADR_W-1:0] w_clr_adr;
    logic             w_clr_last;
    logic [3:0]       r_defer_cnt;
    logic             r_lk_valid;
    logic             w_wr_win;
    logic             w_lk_win;

`ifdef VMEM1_CLEAR_EN
    logic [ADR_W-1:0] r_clr_adr;

    // Sweep address: restarts at 0 on reset, advances once per clear cycle
    // and wraps back to 0 after the last entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_adr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_adr <= r_clr_adr + ADR_W'(1);
        end
    end

    assign w_clr_adr = r_clr_adr;
`else
    assign w_clr_adr = '0;
`endif

    assign w_clr_last = &w_clr_adr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, arbitration decision and RAM port drive
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_win      = 1'b0;
        w_lk_win      = 1'b0;
        bus.lk_gnt    = 1'b0;
        bus.wr_gnt    = 1'b0;
        bus.ram_adr   = '0;
        bus.ram_rp    = 1'b0;
        bus.ram_wp    = 1'b0;
        bus.ram_wdata = '0;
        bus.busy      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                bus.busy      = 1'b1;
                bus.ram_wp    = 1'b1;
                bus.ram_adr   = w_clr_adr;
                bus.ram_wdata = CLEAR_VALUE;
                if (w_clr_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                // A write that has been deferred MAX_DEFER times overrides
                // lookups; otherwise lookups win and writes take idle slots.
                if (bus.wr_req && ((r_defer_cnt == c_MAX_DEFER) || !bus.lk_req)) begin
                    w_wr_win = 1'b1;
                end else if (bus.lk_req) begin
                    w_lk_win = 1'b1;
                end
                if (w_wr_win) begin
                    bus.wr_gnt    = 1'b1;
                    bus.ram_wp    = 1'b1;
                    bus.ram_adr   = bus.wr_adr;
                    bus.ram_wdata = bus.wr_data;
                end else if (w_lk_win) begin
                    bus.lk_gnt  = 1'b1;
                    bus.ram_rp  = 1'b1;
                    bus.ram_adr = bus.lk_adr;
                end
            end
        endcase
    end

    // Defer counter: counts lookups won over a pending write, saturating;
    // cleared when the write is served or the write request is withdrawn.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_defer_cnt <= '0;
        end else if (w_wr_win || !bus.wr_req) begin
            r_defer_cnt <= '0;
        end else if (w_lk_win && (r_defer_cnt != c_MAX_DEFER)) begin
            r_defer_cnt <= r_defer_cnt + 4'd1;
        end
    end

    // Lookup data valid: one cycle after each grant, killed by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lk_valid <= 1'b0;
        end else begin
            r_lk_valid <= w_lk_win;
        end
    end

    assign bus.lk_valid = r_lk_valid;
    assign bus.lk_data  = bus.ram_q;

endmodule

`default_nettype wire

// File: tb/tb_vmem1_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_vmem1_arb
// Description : Directed self-checking bench for vmem1_arb with a behavioural
//               1024x24 map RAM and a lookup-data scoreboard. Follows the
//               VMEM1_CLEAR_EN setting of the design build.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vmem1_arb;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vmem1_arb_if #(.ADR_W(10), .DATA_W(24)) bus ();

    vmem1_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Behavioural map RAM: synchronous write, registered read, read
    // suppressed while writing.
    logic [23:0] ram [0:1023];
    always @(posedge clk) begin
        if (bus.ram_wp) begin
            ram[bus.ram_adr] <= bus.ram_wdata;
        end else if (bus.ram_rp) begin
            bus.ram_q <= ram[bus.ram_adr];
        end
    end

    int          vectors     = 0;
    int          miscompares = 0;
    logic [23:0] exp_q [$];
    logic [23:0] shadow [0:1023];
    logic [23:0] mon_exp;
    bit          mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Per-cycle monitor: port exclusivity and lookup-data scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rp_wp_exclusive", 32'(bus.ram_rp & bus.ram_wp), 32'd0);
            if (bus.lk_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_lk_valid", 32'(bus.lk_valid), 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("lk_data", 32'(bus.lk_data), 32'(mon_exp));
                end
            end
        end
    end

    task automatic do_write(input logic [9:0] a, input logic [23:0] d, input string tag);
        bus.wr_req  = 1'b1;
        bus.wr_adr  = a;
        bus.wr_data = d;
        smp();
        chk({tag, "_wr_gnt"}, 32'(bus.wr_gnt), 32'd1);
        chk({tag, "_ram_adr"}, 32'(bus.ram_adr), 32'(a));
        chk({tag, "_ram_wdata"}, 32'(bus.ram_wdata), 32'(d));
        shadow[a] = d;
        cyc();
        bus.wr_req = 1'b0;
    endtask

    task automatic do_lookup(input logic [9:0] a, input string tag);
        bus.lk_req = 1'b1;
        bus.lk_adr = a;
        exp_q.push_back(shadow[a]);
        smp();
        chk({tag, "_lk_gnt"}, 32'(bus.lk_gnt), 32'd1);
        chk({tag, "_ram_rp"}, 32'(bus.ram_rp), 32'd1);
        chk({tag, "_ram_adr"}, 32'(bus.ram_adr), 32'(a));
        chk({tag, "_valid_early"}, 32'(bus.lk_valid), 32'd0);
        cyc();
        bus.lk_req = 1'b0;
        smp();
        chk({tag, "_lk_valid"}, 32'(bus.lk_valid), 32'd1);
        chk({tag, "_idle_adr"}, 32'(bus.ram_adr), 32'd0);
        cyc();
        smp();
        chk({tag, "_valid_once"}, 32'(bus.lk_valid), 32'd0);
        cyc();
    endtask

    // Lookups held continuously with a write raised in the first cycle and
    // the defer count at 0: four lookups, then the write, then lookups resume.
    task automatic starve(input logic [9:0] la, input logic [9:0] wa,
                          input logic [23:0] wd, input string tag);
        bus.lk_req  = 1'b1;
        bus.lk_adr  = la;
        bus.wr_req  = 1'b1;
        bus.wr_adr  = wa;
        bus.wr_data = wd;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(shadow[la]);
            smp();
            chk({tag, "_lk_wins"}, 32'({bus.lk_gnt, bus.wr_gnt}), 32'b10);
            cyc();
        end
        smp();
        chk({tag, "_wr_forced"}, 32'({bus.lk_gnt, bus.wr_gnt}), 32'b01);
        chk({tag, "_wr_data"}, 32'(bus.ram_wdata), 32'(wd));
        shadow[wa] = wd;
        cyc();
        bus.wr_req = 1'b0;
        exp_q.push_back(shadow[la]);
        smp();
        chk({tag, "_lk_resume"}, 32'(bus.lk_gnt), 32'd1);
        cyc();
        bus.lk_req = 1'b0;
        smp();
        cyc();
    endtask

`ifdef VMEM1_CLEAR_EN
    // Entered at the negedge of the first sweep cycle; leaves at the negedge
    // of the first RUN cycle.
    task automatic sweep_check(input string tag);
        int n   = 0;
        int bad = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            if (bus.ram_adr !== n[9:0] || bus.ram_wp !== 1'b1 || bus.ram_rp !== 1'b0 ||
                bus.ram_wdata !== 24'h000000 || bus.lk_gnt !== 1'b0 || bus.wr_gnt !== 1'b0) begin
                bad++;
            end
            n++;
            smp();
        end
        chk({tag, "_cells"}, 32'(bad), 32'd0);
        chk({tag, "_length"}, 32'(n), 32'd1024);
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        for (int i = 0; i < 1024; i++) shadow[i] = 24'h000000;
    endtask
`endif

    initial begin
        reset       = 1'b1;
        bus.lk_req  = 1'b0;
        bus.lk_adr  = '0;
        bus.wr_req  = 1'b0;
        bus.wr_adr  = '0;
        bus.wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        smp();
        chk("reset_lk_valid", 32'(bus.lk_valid), 32'd0);
        chk("reset_grants", 32'({bus.lk_gnt, bus.wr_gnt}), 32'd0);
`ifdef VMEM1_CLEAR_EN
        chk("reset_busy", 32'(bus.busy), 32'd1);
`else
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_ram_en", 32'({bus.ram_rp, bus.ram_wp}), 32'd0);
`endif
        mon_en = 1'b1;
        cyc();
        reset = 1'b0;
`ifdef VMEM1_CLEAR_EN
        smp();
        sweep_check("sweep");
        cyc();
        do_lookup(10'h3FF, "clear_3ff");
`endif

        // basic write then immediate read-back
        do_write(10'h155, 24'hABCDEF, "basic_wr");
        do_lookup(10'h155, "basic_rd");

        do_write(10'h000, 24'h111111, "wr_000");
        do_write(10'h3FF, 24'hFFFFFF, "wr_3ff");
        do_write(10'h2AA, 24'h5A5A5A, "wr_2aa");
        do_lookup(10'h000, "rd_000");

        // starvation bound with lookups held high
        starve(10'h3FF, 10'h0AA, 24'h123456, "starve1");

        // simultaneous requests with no pressure
        bus.lk_req  = 1'b1;
        bus.lk_adr  = 10'h0AA;
        bus.wr_req  = 1'b1;
        bus.wr_adr  = 10'h1C3;
        bus.wr_data = 24'h0C0FFE;
        exp_q.push_back(shadow[10'h0AA]);
        smp();
        chk("simul_lk_first", 32'({bus.lk_gnt, bus.wr_gnt}), 32'b10);
        cyc();
        bus.lk_req = 1'b0;
        smp();
        chk("simul_wr_next", 32'({bus.lk_gnt, bus.wr_gnt}), 32'b01);
        chk("simul_wr_adr", 32'(bus.ram_adr), 32'h1C3);
        shadow[10'h1C3] = 24'h0C0FFE;
        cyc();
        bus.wr_req = 1'b0;
        // the write just served must have cleared the defer count
        starve(10'h1C3, 10'h2AA, 24'hA5A5A5, "starve2");

        // withdrawn write clears the defer count
        bus.lk_req  = 1'b1;
        bus.lk_adr  = 10'h155;
        bus.wr_req  = 1'b1;
        bus.wr_adr  = 10'h000;
        bus.wr_data = 24'h222222;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(shadow[10'h155]);
            smp();
            chk("drop_lk_wins", 32'({bus.lk_gnt, bus.wr_gnt}), 32'b10);
            cyc();
        end
        bus.wr_req = 1'b0;
        exp_q.push_back(shadow[10'h155]);
        smp();
        chk("drop_lk_alone", 32'(bus.lk_gnt), 32'd1);
        cyc();
        bus.lk_req = 1'b0;
        smp();
        cyc();
        starve(10'h155, 10'h000, 24'h222222, "starve3");
        do_lookup(10'h000, "rd_000b");

        // reset asserted in a cycle that grants a lookup
        reset      = 1'b1;
        bus.lk_req = 1'b1;
        bus.lk_adr = 10'h155;
        smp();
        chk("rst_lk_gnt", 32'(bus.lk_gnt), 32'd1);
        cyc();
        reset      = 1'b0;
        bus.lk_req = 1'b0;
        smp();
        chk("rst_lk_valid_killed", 32'(bus.lk_valid), 32'd0);
`ifdef VMEM1_CLEAR_EN
        begin
            int n = 0;
            while (bus.ram_adr !== 10'h200 && n < 2000) begin
                smp();
                n++;
            end
            chk("midsweep_reach_200", 32'(bus.ram_adr), 32'h200);
        end
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        smp();
        sweep_check("resweep");
        cyc();
        do_lookup(10'h3FF, "resweep_3ff");
        do_lookup(10'h155, "resweep_155");
`else
        cyc();
        do_lookup(10'h155, "post_rst_155");
`endif

        repeat (3) cyc();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
